// File: rtl/conv_rd_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_rd_arb_req_if / conv_rd_arb_bus_if
// Description : Signal bundles for the convolution read-channel arbiter.
//               conv_rd_arb_req_if : one read requester (address + data
//                                    return + busy status).
//               conv_rd_arb_bus_if : shared bus read port (address channel
//                                    plus returning read beats).
//               master modport = side that issues addresses,
//               slave modport  = side that accepts them.
// Revision    : 1.0 - initial release
// ============================================================================

interface conv_rd_arb_req_if;
    logic        arvalid;
    logic        arready;
    logic [27:0] araddr;
    logic [3:0]  arlen;
    logic        aruserap;
    logic        rvalid;
    logic        rlast;
    logic [31:0] rdata;
    logic        busy;

    modport master (
        output arvalid, araddr, arlen, aruserap,
        input  arready, rvalid, rlast, rdata, busy
    );

    modport slave (
        input  arvalid, araddr, arlen, aruserap,
        output arready, rvalid, rlast, rdata, busy
    );
endinterface

interface conv_rd_arb_bus_if;
    logic        arvalid;
    logic        arready;
    logic [27:0] araddr;
    logic [3:0]  arlen;
    logic [3:0]  arusrid;
    logic        aruserap;
    logic        rvalid;
    logic        rlast;
    logic [3:0]  rid;
    logic [31:0] rdata;

    modport master (
        output arvalid, araddr, arlen, arusrid, aruserap,
        input  arready, rvalid, rlast, rid, rdata
    );

    modport slave (
        input  arvalid, araddr, arlen, arusrid, aruserap,
        output arready, rvalid, rlast, rid, rdata
    );
endinterface

`default_nettype wire

// File: rtl/conv_rd_arb.sv
`default_nettype none
// ============================================================================
// Module      : conv_rd_arb
// Description : Shares one bus read port between the image-fetch requester
//               (m0) and the filter-fetch requester (m1). Address requests are
//               granted round-robin and tagged with a per-port ID; returning
//               beats are steered back by ID. Outstanding bursts are counted
//               per port and capped at MAX_OUT.
// Ports       : clk, rst_n (async, active-low)
//               m0, m1  : requester bundles (slave side)
//               bus     : shared bus read port (master side)
//               err_rid : sticky flag, beat with unknown ID or for a port with
//                         nothing outstanding
// Revision    : 1.0 - initial release
// ============================================================================

module conv_rd_arb #(
    parameter logic [3:0] ID0     = 4'd0,
    parameter logic [3:0] ID1     = 4'd1,
    parameter int         MAX_OUT = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    conv_rd_arb_req_if.slave   m0,
    conv_rd_arb_req_if.slave   m1,
    conv_rd_arb_bus_if.master  bus,
    output logic               err_rid
);

    localparam logic [3:0] c_max_out = 4'(MAX_OUT);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_ptr;          // port preferred when both are eligible
    logic        r_gnt;          // port owning the address in flight
    logic [3:0]  r_cnt0, r_cnt1;
    logic        r_busy0, r_busy1;
    logic [27:0] r_araddr;
    logic [3:0]  r_arlen;
    logic [3:0]  r_arusrid;
    logic        r_aruserap;
    logic        r_rvalid0, r_rvalid1;
    logic        r_rlast0, r_rlast1;
    logic [31:0] r_rdata0, r_rdata1;
    logic        r_err;

    logic        w_elig0, w_elig1;
    logic        w_grant, w_sel, w_hs;
    logic        w_hit0, w_hit1;
    logic        w_inc0, w_inc1, w_dec0, w_dec1;
    logic        w_err;

    // ------------------------------------------------------------------
    // Arbitration FSM, next state and grant
    // ------------------------------------------------------------------
    always_comb begin
        w_elig0     = m0.arvalid && (r_cnt0 < c_max_out);
        w_elig1     = m1.arvalid && (r_cnt1 < c_max_out);
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_sel       = 1'b0;
        w_hs        = 1'b0;
        case (r_state)
            S_IDLE: begin
                // arready is combinational; gate with rst_n so it drops
                // the instant reset is applied.
                if ((w_elig0 || w_elig1) && rst_n) begin
                    w_grant     = 1'b1;
                    w_sel       = (w_elig0 && w_elig1) ? r_ptr : w_elig1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.arready) begin
                    w_hs        = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= 1'b0;
            r_gnt      <= 1'b0;
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_arusrid  <= '0;
            r_aruserap <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_gnt      <= w_sel;
                r_araddr   <= w_sel ? m1.araddr   : m0.araddr;
                r_arlen    <= w_sel ? m1.arlen    : m0.arlen;
                r_aruserap <= w_sel ? m1.aruserap : m0.aruserap;
                r_arusrid  <= w_sel ? ID1         : ID0;
            end
            if (w_hs) begin
                r_ptr <= ~r_gnt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outstanding tracking and beat steering. Beats for a port with no
    // outstanding burst are dropped and flagged, as are unknown IDs.
    // ------------------------------------------------------------------
    always_comb begin
        w_hit0 = bus.rvalid && (bus.rid == ID0) && (r_cnt0 != 4'd0);
        w_hit1 = bus.rvalid && (bus.rid == ID1) && (r_cnt1 != 4'd0);
        w_inc0 = w_hs && !r_gnt;
        w_inc1 = w_hs &&  r_gnt;
        w_dec0 = w_hit0 && bus.rlast;
        w_dec1 = w_hit1 && bus.rlast;
        w_err  = bus.rvalid &&
                 (((bus.rid == ID0) && (r_cnt0 == 4'd0)) ||
                  ((bus.rid == ID1) && (r_cnt1 == 4'd0)) ||
                  ((bus.rid != ID0) && (bus.rid != ID1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0    <= '0;
            r_cnt1    <= '0;
            r_busy0   <= 1'b0;
            r_busy1   <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rlast0  <= 1'b0;
            r_rlast1  <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_err     <= 1'b0;
        end else begin
            // Simultaneous increment and decrement cancel out; the grant
            // path never lets a count exceed MAX_OUT.
            case ({w_inc0, w_dec0})
                2'b10:   r_cnt0 <= r_cnt0 + 4'd1;
                2'b01:   r_cnt0 <= r_cnt0 - 4'd1;
                default: r_cnt0 <= r_cnt0;
            endcase
            case ({w_inc1, w_dec1})
                2'b10:   r_cnt1 <= r_cnt1 + 4'd1;
                2'b01:   r_cnt1 <= r_cnt1 - 4'd1;
                default: r_cnt1 <= r_cnt1;
            endcase
            r_busy0   <= (r_cnt0 != 4'd0);
            r_busy1   <= (r_cnt1 != 4'd0);
            r_rvalid0 <= w_hit0;
            r_rvalid1 <= w_hit1;
            if (w_hit0) begin
                r_rlast0 <= bus.rlast;
                r_rdata0 <= bus.rdata;
            end
            if (w_hit1) begin
                r_rlast1 <= bus.rlast;
                r_rdata1 <= bus.rdata;
            end
            if (w_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign m0.arready   = w_grant && !w_sel;
    assign m1.arready   = w_grant &&  w_sel;
    assign m0.rvalid    = r_rvalid0;
    assign m0.rlast     = r_rlast0;
    assign m0.rdata     = r_rdata0;
    assign m0.busy      = r_busy0;
    assign m1.rvalid    = r_rvalid1;
    assign m1.rlast     = r_rlast1;
    assign m1.rdata     = r_rdata1;
    assign m1.busy      = r_busy1;
    assign bus.arvalid  = (r_state == S_ISSUE);
    assign bus.araddr   = r_araddr;
    assign bus.arlen    = r_arlen;
    assign bus.arusrid  = r_arusrid;
    assign bus.aruserap = r_aruserap;
    assign err_rid      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_conv_rd_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_rd_arb
// Description : Self-checking bench for conv_rd_arb. Directed stimulus pushes
//               expected bus addresses and routed beats into queues; monitors
//               pop and compare them whenever the DUT presents an output.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_conv_rd_arb;

    localparam logic [3:0] c_id0 = 4'd0;
    localparam logic [3:0] c_id1 = 4'd1;

    typedef struct packed {
        logic [3:0]  id;
        logic [27:0] addr;
        logic [3:0]  len;
        logic        ap;
    } ar_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [31:0] cyc;
    } rb_t;

    logic clk;
    logic rst_n;
    logic err_rid;
    logic [31:0] cyc;
    int total;
    int bad;

    ar_t q_ar[$];
    rb_t q_r0[$];
    rb_t q_r1[$];

    conv_rd_arb_req_if u_m0 ();
    conv_rd_arb_req_if u_m1 ();
    conv_rd_arb_bus_if u_bus ();

    conv_rd_arb #(.ID0(c_id0), .ID1(c_id1), .MAX_OUT(4)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m0      (u_m0.slave),
        .m1      (u_m1.slave),
        .bus     (u_bus.master),
        .err_rid (err_rid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        u_m0.arvalid = 0; u_m0.araddr = '0; u_m0.arlen = '0; u_m0.aruserap = 0;
        u_m1.arvalid = 0; u_m1.araddr = '0; u_m1.arlen = '0; u_m1.aruserap = 0;
        u_bus.arready = 0; u_bus.rvalid = 0; u_bus.rlast = 0;
        u_bus.rid = '0; u_bus.rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        q_ar.delete(); q_r0.delete(); q_r1.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    // Drives one bus beat for this cycle; dst 0/1 = expected routed port,
    // any other value = beat must not appear on either port.
    task automatic beat(input logic [3:0] id, input logic last, input logic [31:0] d, input int dst);
        rb_t e;
        u_bus.rvalid = 1; u_bus.rid = id; u_bus.rlast = last; u_bus.rdata = d;
        e.data = d; e.last = last; e.cyc = cyc + 1;
        if (dst == 0) q_r0.push_back(e);
        else if (dst == 1) q_r1.push_back(e);
        step();
        u_bus.rvalid = 0;
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin : mon
        ar_t ea;
        rb_t eb;
        if (rst_n === 1'b1) begin
            if (u_bus.arvalid && u_bus.arready) begin
                if (q_ar.size() == 0) chk("ar_unexpected", 32'(u_bus.araddr), 32'hFFFF_FFFF);
                else begin
                    ea = q_ar.pop_front();
                    chk("ar_id",   32'(u_bus.arusrid),  32'(ea.id));
                    chk("ar_addr", 32'(u_bus.araddr),   32'(ea.addr));
                    chk("ar_len",  32'(u_bus.arlen),    32'(ea.len));
                    chk("ar_ap",   32'(u_bus.aruserap), 32'(ea.ap));
                end
            end
            if (u_m0.rvalid) begin
                if (q_r0.size() == 0) chk("r0_unexpected", u_m0.rdata, 32'hFFFF_FFFF);
                else begin
                    eb = q_r0.pop_front();
                    chk("r0_data", u_m0.rdata, eb.data);
                    chk("r0_last", 32'(u_m0.rlast), 32'(eb.last));
                    chk("r0_cyc",  cyc, eb.cyc);
                end
            end
            if (u_m1.rvalid) begin
                if (q_r1.size() == 0) chk("r1_unexpected", u_m1.rdata, 32'hFFFF_FFFF);
                else begin
                    eb = q_r1.pop_front();
                    chk("r1_data", u_m1.rdata, eb.data);
                    chk("r1_last", 32'(u_m1.rlast), 32'(eb.last));
                    chk("r1_cyc",  cyc, eb.cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed stimulus ----------------
    initial begin : stim
        ar_t a;
        logic [27:0] ad0, ad1;
        total = 0;
        bad = 0;
        rst_n = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        neg();
        chk("rst_arvalid", 32'(u_bus.arvalid), 0);
        chk("rst_araddr",  32'(u_bus.araddr), 0);
        chk("rst_busy0",   32'(u_m0.busy), 0);
        chk("rst_err",     32'(err_rid), 0);

        // ---- single port-0 request, data return ----
        do_reset();
        u_bus.arready = 1;
        u_m0.arvalid = 1; u_m0.araddr = 28'h0000040; u_m0.arlen = 4'd15; u_m0.aruserap = 1;
        a = '{id: c_id0, addr: 28'h0000040, len: 4'd15, ap: 1'b1};
        q_ar.push_back(a);
        neg();
        chk("t1_m0_arready_c0", 32'(u_m0.arready), 1);
        chk("t1_m1_arready_c0", 32'(u_m1.arready), 0);
        chk("t1_arvalid_c0",    32'(u_bus.arvalid), 0);
        step(); u_m0.arvalid = 0;
        neg();
        chk("t1_arvalid_c1", 32'(u_bus.arvalid), 1);
        step(); neg();
        chk("t1_busy_c2",    32'(u_m0.busy), 0);
        chk("t1_arvalid_c2", 32'(u_bus.arvalid), 0);
        step(); neg();
        chk("t1_busy_c3", 32'(u_m0.busy), 1);
        step();
        for (int i = 0; i < 16; i++) beat(c_id0, i == 15, 32'hA000 + 32'(i), 0);
        step(); step(); neg();
        chk("t1_busy_done", 32'(u_m0.busy), 0);
        chk("t1_err", 32'(err_rid), 0);

        // ---- both ports request continuously ----
        do_reset();
        u_bus.arready = 1;
        ad0 = 28'h0000100; ad1 = 28'h0000200;
        u_m0.arvalid = 1; u_m0.araddr = ad0; u_m0.arlen = 4'd3;
        u_m1.arvalid = 1; u_m1.araddr = ad1; u_m1.arlen = 4'd7;
        for (int c = 0; c < 8; c++) begin
            neg();
            chk($sformatf("t2_m0_arready_c%0d", c), 32'(u_m0.arready), 32'(c % 4 == 0));
            chk($sformatf("t2_m1_arready_c%0d", c), 32'(u_m1.arready), 32'(c % 4 == 2));
            chk($sformatf("t2_arvalid_c%0d", c),    32'(u_bus.arvalid), 32'(c % 2 == 1));
            if (u_m0.arready) begin
                a = '{id: c_id0, addr: ad0, len: 4'd3, ap: 1'b0};
                q_ar.push_back(a);
                ad0 = ad0 + 28'h10;
            end
            if (u_m1.arready) begin
                a = '{id: c_id1, addr: ad1, len: 4'd7, ap: 1'b0};
                q_ar.push_back(a);
                ad1 = ad1 + 28'h10;
            end
            step();
            u_m0.araddr = ad0; u_m1.araddr = ad1;
        end
        u_m0.arvalid = 0; u_m1.arvalid = 0;
        step(); step();

        // ---- bus_arready held low in ISSUE ----
        do_reset();
        u_m0.arvalid = 1; u_m0.araddr = 28'h0ABCDEF; u_m0.arlen = 4'd5;
        u_m1.arvalid = 1; u_m1.araddr = 28'h0000300; u_m1.arlen = 4'd1;
        neg();
        chk("t3_m0_arready", 32'(u_m0.arready), 1);
        a = '{id: c_id0, addr: 28'h0ABCDEF, len: 4'd5, ap: 1'b0};
        q_ar.push_back(a);
        step(); u_m0.arvalid = 0;
        for (int k = 0; k < 5; k++) begin
            neg();
            chk("t3_arvalid", 32'(u_bus.arvalid), 1);
            chk("t3_araddr",  32'(u_bus.araddr), 32'h0ABCDEF);
            chk("t3_arlen",   32'(u_bus.arlen), 5);
            chk("t3_arusrid", 32'(u_bus.arusrid), 0);
            chk("t3_m0_arready", 32'(u_m0.arready), 0);
            chk("t3_m1_arready", 32'(u_m1.arready), 0);
            step();
        end
        u_bus.arready = 1;
        neg(); step(); neg();
        chk("t3_m1_granted_after", 32'(u_m1.arready), 1);
        a = '{id: c_id1, addr: 28'h0000300, len: 4'd1, ap: 1'b0};
        q_ar.push_back(a);
        step(); u_m1.arvalid = 0;
        neg(); step();

        // ---- port 1 hits MAX_OUT ----
        do_reset();
        u_bus.arready = 1;
        ad1 = 28'h0000400;
        u_m1.arvalid = 1; u_m1.araddr = ad1; u_m1.arlen = 4'd0;
        for (int c = 0; c < 8; c++) begin
            neg();
            chk($sformatf("t4_m1_arready_c%0d", c), 32'(u_m1.arready), 32'(c % 2 == 0));
            if (u_m1.arready) begin
                a = '{id: c_id1, addr: ad1, len: 4'd0, ap: 1'b0};
                q_ar.push_back(a);
                ad1 = ad1 + 28'h4;
            end
            step();
            u_m1.araddr = ad1;
        end
        u_m0.arvalid = 1; u_m0.araddr = 28'h0000500; u_m0.arlen = 4'd2;
        neg();
        chk("t4_m1_stall_c8", 32'(u_m1.arready), 0);
        chk("t4_m0_grant_c8", 32'(u_m0.arready), 1);
        a = '{id: c_id0, addr: 28'h0000500, len: 4'd2, ap: 1'b0};
        q_ar.push_back(a);
        step(); u_m0.arvalid = 0;
        neg(); step();
        // cycle 10: still full; one rlast for port 1 arrives this cycle
        u_bus.rvalid = 1; u_bus.rid = c_id1; u_bus.rlast = 1; u_bus.rdata = 32'h0000_1234;
        q_r1.push_back('{data: 32'h0000_1234, last: 1'b1, cyc: cyc + 1});
        neg();
        chk("t4_m1_stall_c10", 32'(u_m1.arready), 0);
        step(); u_bus.rvalid = 0;
        neg();
        chk("t4_m1_regrant_c11", 32'(u_m1.arready), 1);
        a = '{id: c_id1, addr: ad1, len: 4'd0, ap: 1'b0};
        q_ar.push_back(a);
        step(); u_m1.arvalid = 0;
        neg(); step();

        // ---- 16-beat burst for port 1, then drain the rest ----
        for (int i = 0; i < 16; i++) beat(c_id1, i == 15, 32'hB0000 + 32'(i), 1);
        neg();
        chk("t5_busy1_mid", 32'(u_m1.busy), 1);
        chk("t5_busy0_mid", 32'(u_m0.busy), 1);
        step();
        for (int i = 0; i < 3; i++) beat(c_id1, 1'b1, 32'hC000 + 32'(i), 1);
        step(); step(); neg();
        chk("t5_busy1_done", 32'(u_m1.busy), 0);
        chk("t5_err", 32'(err_rid), 0);

        // ---- unknown ID, then asynchronous reset ----
        step();
        beat(4'd7, 1'b1, 32'hDEAD_BEEF, 2);
        neg();
        chk("t6_err_set", 32'(err_rid), 1);
        step();
        u_bus.arready = 0;
        u_m0.arvalid = 1; u_m0.araddr = 28'h0000600; u_m0.arlen = 4'd1;
        neg(); step();
        neg();
        chk("t6_arvalid_pre", 32'(u_bus.arvalid), 1);
        #2;
        rst_n = 0;
        #1;
        chk("t6_rst_arvalid",  32'(u_bus.arvalid), 0);
        chk("t6_rst_araddr",   32'(u_bus.araddr), 0);
        chk("t6_rst_arlen",    32'(u_bus.arlen), 0);
        chk("t6_rst_arusrid",  32'(u_bus.arusrid), 0);
        chk("t6_rst_m0_arready", 32'(u_m0.arready), 0);
        chk("t6_rst_m0_busy",  32'(u_m0.busy), 0);
        chk("t6_rst_err",      32'(err_rid), 0);
        chk("t6_rst_m1_rdata", u_m1.rdata, 0);
        chk("t6_rst_m1_rlast", 32'(u_m1.rlast), 0);
        chk("t6_rst_m1_rvalid", 32'(u_m1.rvalid), 0);
        do_reset();
        step(); neg();

        chk("end_q_ar", 32'(q_ar.size()), 0);
        chk("end_q_r0", 32'(q_r0.size()), 0);
        chk("end_q_r1", 32'(q_r1.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
